// File: rtl/dut_run_host.sv
// dut_run_host: host-side run controller for the processor top level.
//   Back-door loads data memory from a host byte stream while the core is held
//   in init, releases start, waits for halt or a cycle-budget timeout, then
//   streams a fixed result window out of data memory to the host.
// Ports:
//   CLK, reset_n                         clock (posedge), async active-low reset
//   ld_valid/ld_ready/ld_addr/ld_data/ld_last   host load stream
//   dut_start, dut_halt                  core init/start and done handshake
//   mem_sel, mem_wr_en, mem_addr, mem_wr_data, mem_rd_data   data-memory port
//   out_valid/out_ready/out_data/out_last       result stream to host
//   run_cycles, busy, done, timeout, clear      status and DONE->IDLE release
module dut_run_host #(
  parameter logic [7:0]  RD_BASE      = 8'd64,
  parameter int          RD_LEN       = 16,
  parameter int          START_CYCLES = 2,
  parameter logic [15:0] TIMEOUT      = 16'd50000
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [7:0]  ld_addr,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        dut_start,
  input  logic        dut_halt,
  output logic        mem_sel,
  output logic        mem_wr_en,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wr_data,
  input  logic [7:0]  mem_rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic [15:0] run_cycles,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  input  logic        clear
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_RUN, S_DRAIN, S_DONE
  } state_e;

  localparam logic [7:0]  LAST_IDX   = 8'(RD_LEN - 1);
  localparam logic [15:0] START_LAST = 16'(START_CYCLES - 1);
  localparam logic [15:0] TO_LAST    = TIMEOUT - 16'd1;

  state_e      state_q;
  logic [7:0]  idx_q,  idx_d;
  logic [15:0] run_q,  run_d;
  logic [15:0] scnt_q;
  logic        to_q;

  logic ld_fire, out_fire, in_load, in_drain;

  assign in_load  = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign in_drain = (state_q == S_DRAIN);
  assign ld_fire  = ld_valid && ld_ready;
  assign out_fire = out_valid && out_ready;

  assign idx_d = idx_q + 8'd1;
  assign run_d = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      run_q   <= '0;
      scnt_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (ld_fire) begin
          run_q   <= '0;
          to_q    <= 1'b0;
          scnt_q  <= '0;
          state_q <= ld_last ? S_START : S_LOAD;
        end
        S_LOAD: if (ld_fire && ld_last) begin
          scnt_q  <= '0;
          state_q <= S_START;
        end
        S_START: begin
          if (scnt_q == START_LAST) state_q <= S_RUN;
          else                      scnt_q  <= scnt_q + 16'd1;
        end
        S_RUN: begin
          run_q <= run_d;
          // run_q is 0 only during the first RUN cycle (it never wraps), so a
          // halt left over from the previous run is ignored there. Halt beats
          // timeout when both occur together.
          if (dut_halt && (run_q != 16'd0)) begin
            idx_q   <= '0;
            state_q <= S_DRAIN;
          end else if (run_q == TO_LAST) begin
            to_q    <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DRAIN: if (out_fire) begin
          if (out_last) begin
            idx_q   <= '0;
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_d;
          end
        end
        S_DONE:  if (clear) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state so an async reset takes
  // effect on them immediately. Load writes pass through in the beat's cycle.
  assign ld_ready    = in_load;
  assign mem_wr_en   = ld_fire;
  assign mem_wr_data = ld_fire ? ld_data : 8'd0;
  assign mem_addr    = ld_fire  ? ld_addr :
                       in_drain ? RD_BASE + idx_q : 8'd0;
  assign dut_start   = in_load || (state_q == S_START);
  assign mem_sel     = (state_q != S_RUN);
  // Address is held while not ready and the core is stopped, so the
  // combinational read data stays stable under backpressure.
  assign out_valid   = in_drain;
  assign out_data    = in_drain ? mem_rd_data : 8'd0;
  assign out_last    = in_drain && (idx_q == LAST_IDX);
  assign run_cycles  = run_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign timeout     = to_q;

endmodule

// File: tb/tb_dut_run_host.sv
module tb_dut_run_host;
  logic        CLK = 1'b0;
  logic        reset_n;
  logic        ld_valid, ld_ready, ld_last;
  logic [7:0]  ld_addr, ld_data;
  logic        dut_start, dut_halt;
  logic        mem_sel, mem_wr_en;
  logic [7:0]  mem_addr, mem_wr_data, mem_rd_data;
  logic        out_valid, out_ready, out_last;
  logic [7:0]  out_data;
  logic [15:0] run_cycles;
  logic        busy, done, timeout, clear;

  always #5 CLK = ~CLK;

  dut_run_host #(.RD_BASE(8'd64), .RD_LEN(4), .START_CYCLES(2), .TIMEOUT(16'd20)) u_dut (
    .CLK(CLK), .reset_n(reset_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .dut_start(dut_start), .dut_halt(dut_halt),
    .mem_sel(mem_sel), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .run_cycles(run_cycles), .busy(busy), .done(done), .timeout(timeout), .clear(clear)
  );

  // data memory model
  logic [7:0] mem [0:255];
  always @(posedge CLK) if (mem_sel && mem_wr_en) mem[mem_addr] <= mem_wr_data;
  assign mem_rd_data = mem[mem_addr];

  // core model: halts halt_at cycles after start falls (0 = never)
  int   core_cnt = 0;
  int   halt_at;
  logic force_halt;
  always @(posedge CLK) core_cnt <= dut_start ? 0 : core_cnt + 1;
  assign dut_halt = force_halt || (halt_at != 0 && !dut_start && core_cnt == halt_at - 1);

  typedef struct packed { logic [7:0] d; logic l; } exp_t;
  exp_t sb[$];
  int nchk = 0, nfail = 0, nbeats = 0, nvalid = 0;

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endfunction

  // output monitor / scoreboard, samples mid-low-phase
  logic       hold_v = 1'b0;
  logic [7:0] hold_d = 8'd0;
  always begin
    exp_t e;
    @(negedge CLK); #3;
    if (hold_v) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(hold_d));
    end
    if (out_valid) nvalid++;
    if (out_valid && out_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_last", 32'(out_last), 32'(e.l));
      end
      nbeats++;
    end
    hold_v = out_valid && !out_ready;
    hold_d = out_data;
  end

  task automatic tick();
    @(posedge CLK); @(negedge CLK);
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] d, input logic l);
    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = l;
    #1;
    chk("ld_ready", 32'(ld_ready), 32'd1);
    chk("wr_en", 32'(mem_wr_en), 32'd1);
    chk("wr_addr", 32'(mem_addr), 32'(a));
    chk("wr_data", 32'(mem_wr_data), 32'(d));
    tick();
    ld_valid = 1'b0; ld_last = 1'b0; ld_addr = 8'd0; ld_data = 8'd0;
  endtask

  // called at the negedge right after the last beat's edge; ends at first RUN cycle
  task automatic start_phase();
    chk("st_start0", 32'(dut_start), 32'd1);
    chk("st_ldrdy0", 32'(ld_ready), 32'd0);
    chk("st_wren0", 32'(mem_wr_en), 32'd0);
    tick();
    chk("st_start1", 32'(dut_start), 32'd1);
    tick();
    chk("run_start", 32'(dut_start), 32'd0);
    chk("run_memsel", 32'(mem_sel), 32'd0);
    chk("run_cyc0", 32'(run_cycles), 32'd0);
  endtask

  task automatic push_exp();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.d = 8'(8'hA0 + i);
      e.l = (i == 3);
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input int tmo, output int cyc);
    cyc = 0;
    while (!done && cyc < tmo) begin tick(); cyc++; end
    chk("done", 32'(done), 32'd1);
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_done", 32'(done), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_start", 32'(dut_start), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_start"}, 32'(dut_start), 32'd1);
    chk({tag, "_memsel"}, 32'(mem_sel), 32'd1);
    chk({tag, "_ldrdy"}, 32'(ld_ready), 32'd1);
    chk({tag, "_wren"}, 32'(mem_wr_en), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(mem_wr_data), 32'd0);
    chk({tag, "_ovalid"}, 32'(out_valid), 32'd0);
    chk({tag, "_olast"}, 32'(out_last), 32'd0);
    chk({tag, "_runcyc"}, 32'(run_cycles), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_tmo"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    int cyc, b0, v0;
    logic [3:0] pat;
    reset_n = 1'b0; ld_valid = 1'b0; ld_addr = 8'd0; ld_data = 8'd0; ld_last = 1'b0;
    out_ready = 1'b1; clear = 1'b0; force_halt = 1'b0; halt_at = 10;
    #1;
    check_reset_vals("rst");
    @(negedge CLK); reset_n = 1'b1;
    @(negedge CLK);

    // run 1: load result window plus three bytes at 0..2, core halts after 10, full-rate drain
    for (int i = 0; i < 4; i++) beat(8'(64 + i), 8'(8'hA0 + i), 1'b0);
    beat(8'd0, 8'h11, 1'b0);
    beat(8'd1, 8'h22, 1'b0);
    beat(8'd2, 8'h33, 1'b1);
    chk("mem0", 32'(mem[0]), 32'h11);
    chk("mem1", 32'(mem[1]), 32'h22);
    chk("mem2", 32'(mem[2]), 32'h33);
    push_exp();
    b0 = nbeats; v0 = nvalid;
    start_phase();
    wait_done(100, cyc);
    chk("r1_beats", 32'(nbeats - b0), 32'd4);
    chk("r1_fullrate", 32'(nvalid - v0), 32'd4);
    chk("r1_runcyc", 32'(run_cycles), 32'd10);
    chk("r1_tmo", 32'(timeout), 32'd0);
    do_clear();

    // run 2: same, with out_ready toggling 1,0,0,1
    push_exp();
    b0 = nbeats;
    beat(8'd5, 8'h77, 1'b1);
    start_phase();
    pat = 4'b1001;
    cyc = 0;
    while (!done && cyc < 200) begin out_ready = pat[cyc % 4]; tick(); cyc++; end
    out_ready = 1'b1;
    chk("r2_done", 32'(done), 32'd1);
    chk("r2_beats", 32'(nbeats - b0), 32'd4);
    chk("r2_runcyc", 32'(run_cycles), 32'd10);
    do_clear();

    // run 3: core never halts -> timeout after 20 RUN cycles, no stream
    halt_at = 0;
    v0 = nvalid;
    beat(8'd6, 8'h01, 1'b1);
    start_phase();
    wait_done(100, cyc);
    chk("r3_cycles", 32'(cyc), 32'd20);
    chk("r3_runcyc", 32'(run_cycles), 32'd20);
    chk("r3_tmo", 32'(timeout), 32'd1);
    chk("r3_novalid", 32'(nvalid - v0), 32'd0);
    do_clear();

    // run 4: stale halt on first RUN cycle ignored; halt on timeout cycle wins
    halt_at = 20; force_halt = 1'b1;
    push_exp();
    b0 = nbeats;
    beat(8'd7, 8'h02, 1'b1);
    start_phase();
    tick();
    force_halt = 1'b0;
    chk("r4_noearly", 32'(out_valid), 32'd0);
    chk("r4_busy", 32'(busy), 32'd1);
    chk("r4_runcyc1", 32'(run_cycles), 32'd1);
    cyc = 0;
    while (!out_valid && cyc < 60) begin tick(); cyc++; end
    chk("r4_drain", 32'(out_valid), 32'd1);
    chk("r4_runcyc", 32'(run_cycles), 32'd20);
    chk("r4_tmo", 32'(timeout), 32'd0);
    wait_done(60, cyc);
    chk("r4_beats", 32'(nbeats - b0), 32'd4);
    do_clear();

    // run 5: reset while byte 2 is presented, then a fresh run streams from byte 0
    halt_at = 10;
    push_exp();
    b0 = nbeats;
    beat(8'd8, 8'h03, 1'b1);
    start_phase();
    cyc = 0;
    while (nbeats < b0 + 2 && cyc < 60) begin tick(); cyc++; end
    chk("r5_mid", 32'(nbeats - b0), 32'd2);
    chk("r5_byte2", 32'(out_data), 32'hA2);
    #1 reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    sb.delete();
    @(negedge CLK); reset_n = 1'b1;
    tick();
    push_exp();
    b0 = nbeats;
    beat(8'd9, 8'h04, 1'b1);
    start_phase();
    wait_done(100, cyc);
    chk("r5_beats", 32'(nbeats - b0), 32'd4);
    chk("r5_runcyc", 32'(run_cycles), 32'd10);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    do_clear();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/dut_run_host.md
# dut_run_host

Host-side run controller sitting across from the processor top level. It back-door loads the processor's data memory from a host byte stream while holding the core in init, releases `start`, and waits for `halt` or a cycle-budget timeout. It then streams a fixed result window out of data memory to the host. It is the initiator end of the core's start/halt handshake and a second master on the data-memory port, which it owns whenever the core is not running.

## Interface
- `RD_BASE`, default 8'd64: first data-memory address of the result window.
- `RD_LEN`, default 16: result bytes streamed out (1..256).
- `START_CYCLES`, default 2: cycles `dut_start` stays high after the last load beat (≥1).
- `TIMEOUT`, default 16'd50000: run-cycle budget (≥2).

Ports:
- `CLK` in 1: clock, posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ld_valid` in 1: load beat valid.
- `ld_ready` out 1: load beat accepted when both valid and ready.
- `ld_addr` in 8: data-memory address of the beat.
- `ld_data` in 8: data byte of the beat.
- `ld_last` in 1: final beat of the load.
- `dut_start` out 1: the core's active-high init/start.
- `dut_halt` in 1: the core's done flag.
- `mem_sel` out 1: 1 means the host drives the data-memory port.
- `mem_wr_en` out 1: data-memory write enable.
- `mem_addr` out 8: data-memory address.
- `mem_wr_data` out 8: data-memory write data.
- `mem_rd_data` in 8: data-memory read data, combinational from `mem_addr`.
- `out_valid` out 1: result byte valid.
- `out_ready` in 1: host accepts the result byte.
- `out_data` out 8: result byte.
- `out_last` out 1: final result byte.
- `run_cycles` out 16: cycles spent in RUN, saturating.
- `busy` out 1: not IDLE and not DONE.
- `done` out 1: in DONE.
- `timeout` out 1: the last run hit `TIMEOUT`.
- `clear` in 1: DONE→IDLE pulse.

## Operation
- States: IDLE, LOAD, START, RUN, DRAIN, DONE.
- IDLE: `ld_ready`=1. An accepted beat writes memory and moves to LOAD, or to START if `ld_last` is set. `run_cycles` and `timeout` are cleared on the first accepted beat.
- LOAD: `ld_ready`=1. Each accepted beat drives `mem_wr_en`=1, `mem_addr`=`ld_addr` and `mem_wr_data`=`ld_data` combinationally in the same cycle. A beat with `ld_last` moves to START.
- START: counts `START_CYCLES` cycles, then goes to RUN.
- `dut_start`=1 in IDLE, LOAD and START, so the core is held in init while memory is written. It is 0 in RUN, DRAIN and DONE.
- `mem_sel`=1 in every state except RUN.
- RUN: `run_cycles` increments every cycle and saturates at 16'hFFFF.
  - `dut_halt`=1 → DRAIN. `dut_halt` is ignored in the first RUN cycle, which covers a stale halt from the previous run.
  - If `run_cycles` reaches `TIMEOUT`-1 without halt → DONE with `timeout`=1.
  - Halt and the timeout condition in the same cycle: halt wins and the run goes to DRAIN.
- DRAIN: index `i` runs 0..`RD_LEN`-1.
  - `mem_addr`=`RD_BASE`+`i` (8-bit wrap), `out_data`=`mem_rd_data`, `out_valid`=1.
  - `out_last`=(`i`==`RD_LEN`-1).
  - `i` advances only on `out_valid`&&`out_ready`. A handshake with `out_last` moves to DONE.
  - `out_data` must not change while `out_valid`=1 and `out_ready`=0.
- DONE: `done`=1. `clear`=1 → IDLE. `clear` in any other state is ignored.
- `ld_ready`=0 and `mem_wr_en`=0 outside IDLE/LOAD. `out_valid`=0 outside DRAIN.
- `mem_addr` is 0 when not otherwise driven.

## Timing
- Reset values: state IDLE, `dut_start`=1, `mem_sel`=1, `ld_ready`=1, `mem_wr_en`=0, `mem_addr`=0, `mem_wr_data`=0, `out_valid`=0, `out_last`=0, `run_cycles`=0, `busy`=0, `done`=0, `timeout`=0, DRAIN index=0.
- Reset mid-operation (any state) forces the reset values immediately. No partial stream resumes.
- Last load beat at edge N: START for N+1..N+`START_CYCLES`. `dut_start` falls and `mem_sel` falls at edge N+`START_CYCLES`.
- First RUN cycle: `run_cycles`=0 at its start and reads 1 after it.
- Halt sampled at edge M moves to DRAIN at M. The first `out_valid` is in the following cycle, with `run_cycles` frozen.
- A stream at full rate (`out_ready`=1 throughout) takes exactly `RD_LEN` cycles.
- Timeout: RUN exits after `TIMEOUT` cycles, with `run_cycles`=`TIMEOUT`.

## Test plan
- Load 3 beats (addr 0/1/2, data 8'h11/22/33, last on 2) → three `mem_wr_en` pulses with matching address and data; `dut_start` stays high 2 cycles after the last beat, then falls.
- Model core that halts 10 cycles after `start` falls, `RD_BASE`=64, `RD_LEN`=4, memory 64..67 = A0..A3 → `out_data` A0,A1,A2,A3; `out_last` on A3; `done`=1; `run_cycles`=10.
- Same run with `out_ready` toggling 1,0,0,1,... → each byte is held stable while not ready; no byte is dropped or duplicated; still 4 bytes total.
- `TIMEOUT`=20 with a core that never halts → DONE after 20 RUN cycles, `timeout`=1, no `out_valid`; `clear` → IDLE with `dut_start`=1.
- `dut_halt` already high when RUN is entered and dropping the next cycle → no DRAIN on the first RUN cycle; halt in the cycle where the timeout condition is hit → DRAIN with `timeout`=0.
- `reset_n` low mid-DRAIN (byte 2 of 4) → all outputs at reset values asynchronously; a new load/run afterwards streams from byte 0.
